// File: rtl/uart_rx_param_if.sv
// Receive-side bundle: serial line in, FIFO head with valid/ready handshake and status out.
interface uart_rx_param_if;
  logic       uart_rx;
  logic [7:0] rx_data;
  logic [1:0] rx_err;
  logic       rx_valid;
  logic       rx_ready;
  logic       rx_overrun;
  logic       rx_busy;

  modport master (
    input  uart_rx, rx_ready,
    output rx_data, rx_err, rx_valid, rx_overrun, rx_busy
  );

  modport slave (
    output uart_rx, rx_ready,
    input  rx_data, rx_err, rx_valid, rx_overrun, rx_busy
  );
endinterface

// File: rtl/uart_rx_param.sv
// UART receiver with configurable framing and optional parity (UART_RX_PARITY_EN); a frame enters the FIFO one cycle after its last stop sample.
// Consumer drains the FIFO head via rx_valid/rx_ready; a frame arriving to a full FIFO is dropped and flagged with rx_overrun.
module uart_rx_param #(
  parameter int CLK_DIV    = 434,
  parameter int DATA_BITS  = 8,
  parameter int STOP_BITS  = 1,
  parameter int PARITY_ODD = 0,
  parameter int FIFO_DEPTH = 4
) (
  input logic             clk,
  input logic             rst,
  uart_rx_param_if.master bus
);
  localparam int          AW        = $clog2(FIFO_DEPTH);
  localparam logic [15:0] HALF_CNT  = 16'(CLK_DIV / 2 - 1);
  localparam logic [15:0] FULL_CNT  = 16'(CLK_DIV - 1);
  localparam logic [3:0]  LAST_DATA = 4'(DATA_BITS - 1);
  localparam logic [3:0]  LAST_STOP = 4'(STOP_BITS - 1);
  localparam logic [AW:0] DEPTH_CNT = (AW + 1)'(FIFO_DEPTH);

  if (CLK_DIV < 16 || CLK_DIV > 65535 || DATA_BITS < 5 || DATA_BITS > 8 ||
      STOP_BITS < 1 || STOP_BITS > 2 || PARITY_ODD < 0 || PARITY_ODD > 1 ||
      FIFO_DEPTH < 2 || FIFO_DEPTH > 16 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_cfg
    $error("uart_rx_param: parameter out of legal range");
  end

  typedef enum logic [2:0] {
    IDLE, START, DATA,
`ifdef UART_RX_PARITY_EN
    PAR,
`endif
    STOP, BRKWAIT
  } state_t;

  typedef struct packed {
    logic [1:0] err;
    logic [7:0] data;
  } rx_entry_t;

  state_t                 state;
  logic                   rx_meta, rxs, rxs_q;
  logic [15:0]            cnt;
  logic [3:0]             bit_cnt;
  logic [DATA_BITS-1:0]   shreg;
  logic [7:0]             data_ext;
  logic                   ferr, perr;
  logic                   wr_vld;
  rx_entry_t              wr_dat;

  rx_entry_t              mem [FIFO_DEPTH];
  rx_entry_t              head;
  logic [AW-1:0]          wr_ptr, rd_ptr;
  logic [AW:0]            count;
  logic                   fifo_vld, full, rd_fire, wr_fire, overrun_q;

  always_comb begin
    data_ext = '0;
    data_ext[DATA_BITS-1:0] = shreg;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
      rxs_q   <= 1'b1;
      state   <= IDLE;
      cnt     <= '0;
      bit_cnt <= '0;
      shreg   <= '0;
      ferr    <= 1'b0;
      perr    <= 1'b0;
      wr_vld  <= 1'b0;
      wr_dat  <= '0;
    end else begin
      rx_meta <= bus.uart_rx;
      rxs     <= rx_meta;
      rxs_q   <= rxs;
      wr_vld  <= 1'b0;
      case (state)
        IDLE: begin
          cnt <= '0;
          if (!rxs && rxs_q) begin
            state   <= START;
            bit_cnt <= '0;
            ferr    <= 1'b0;
            perr    <= 1'b0;
          end
        end
        START: begin
          if (cnt == HALF_CNT) begin
            cnt   <= '0;
            state <= rxs ? IDLE : DATA;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        DATA: begin
          if (cnt == FULL_CNT) begin
            cnt   <= '0;
            shreg <= {rxs, shreg[DATA_BITS-1:1]};
            if (bit_cnt == LAST_DATA) begin
              bit_cnt <= '0;
`ifdef UART_RX_PARITY_EN
              state   <= PAR;
`else
              state   <= STOP;
`endif
            end else begin
              bit_cnt <= bit_cnt + 4'd1;
            end
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
`ifdef UART_RX_PARITY_EN
        PAR: begin
          if (cnt == FULL_CNT) begin
            cnt   <= '0;
            perr  <= ((^shreg) ^ rxs) != 1'(PARITY_ODD);
            state <= STOP;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
`endif
        STOP: begin
          if (cnt == FULL_CNT) begin
            cnt <= '0;
            if (bit_cnt == LAST_STOP) begin
              // A low line here is either a bad stop bit or a break; wait it out.
              bit_cnt     <= '0;
              wr_vld      <= 1'b1;
              wr_dat.err  <= {perr, ferr | ~rxs};
              wr_dat.data <= data_ext;
              state       <= rxs ? IDLE : BRKWAIT;
            end else begin
              bit_cnt <= bit_cnt + 4'd1;
              ferr    <= ferr | ~rxs;
            end
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        BRKWAIT: begin
          cnt <= '0;
          if (rxs) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign fifo_vld = count != '0;
  assign full     = count == DEPTH_CNT;
  assign rd_fire  = fifo_vld & bus.rx_ready;
  // A read in the same cycle frees the slot, so a full FIFO still accepts the write.
  assign wr_fire  = wr_vld & (~full | rd_fire);

  always_ff @(posedge clk) begin
    if (wr_fire) mem[wr_ptr] <= wr_dat;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      overrun_q <= 1'b0;
    end else begin
      if (wr_fire) wr_ptr <= wr_ptr + AW'(1);
      if (rd_fire) rd_ptr <= rd_ptr + AW'(1);
      case ({wr_fire, rd_fire})
        2'b10:   count <= count + (AW + 1)'(1);
        2'b01:   count <= count - (AW + 1)'(1);
        default: count <= count;
      endcase
      overrun_q <= wr_vld & ~wr_fire;
    end
  end

  assign head           = mem[rd_ptr];
  assign bus.rx_valid   = fifo_vld;
  assign bus.rx_data    = fifo_vld ? head.data : 8'h00;
  assign bus.rx_err     = fifo_vld ? head.err  : 2'b00;
  assign bus.rx_overrun = overrun_q;
  assign bus.rx_busy    = state != IDLE;
endmodule

// File: tb/tb_uart_rx_param.sv
// Directed bench for uart_rx_param at default parameters; follows UART_RX_PARITY_EN when defined.
module tb_uart_rx_param;
  localparam int DIV = 434;
`ifdef UART_RX_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif
  localparam int FRAME_BITS = PAR_EN ? 11 : 10;
  // Valid must appear within [start edge + (FRAME_BITS-0.5) bits, +5 cycles].
  localparam int LAT_LO = DIV * (2 * FRAME_BITS - 1) / 2;
  localparam int LAT_HI = LAT_LO + 5;

  typedef struct {
    logic [7:0] data;
    bit         bad_par;
    bit         stop_lvl;
    logic [7:0] exp_data;
    logic [1:0] exp_err;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_pass = 0;
  int   n_total = 0;
  int   ovr_seen = 0;
  int   lat;
  int   o0;
  vec_t vecs [4];

  uart_rx_param_if rxif ();

  uart_rx_param dut (
    .clk (clk),
    .rst (rst),
    .bus (rxif)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (rxif.rx_overrun) ovr_seen++;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded 100000 cycles");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic check_lat(input string name, input int n);
    n_total++;
    if (n >= LAT_LO && n <= LAT_HI) n_pass++;
    else $display("FAIL %s: rx_valid after %0d cycles, expected %0d..%0d", name, n, LAT_LO, LAT_HI);
  endtask

  task automatic send_bit(input logic b);
    rxif.uart_rx = b;
    repeat (DIV) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input bit bad_par, input bit stop_lvl);
    logic p;
    p = (^d) ^ bad_par;
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    if (PAR_EN) send_bit(p);
    send_bit(stop_lvl);
    rxif.uart_rx = 1'b1;
  endtask

  task automatic wait_valid(input int budget, output int n);
    n = -1;
    for (int c = 1; c <= budget && n < 0; c++) begin
      @(negedge clk);
      if (rxif.rx_valid) n = c;
    end
  endtask

  task automatic pop();
    @(negedge clk);
    rxif.rx_ready = 1'b1;
    @(negedge clk);
    rxif.rx_ready = 1'b0;
  endtask

  initial begin
    vecs[0] = '{8'h55, 1'b0, 1'b1, 8'h55, 2'b00};
    vecs[1] = '{8'hA3, 1'b1, 1'b1, 8'hA3, {PAR_EN, 1'b0}};
    vecs[2] = '{8'h00, 1'b0, 1'b0, 8'h00, 2'b01};
    vecs[3] = '{8'h81, 1'b0, 1'b1, 8'h81, 2'b00};

    rxif.uart_rx  = 1'b1;
    rxif.rx_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_outputs", {rxif.rx_valid, rxif.rx_data, rxif.rx_err, rxif.rx_overrun, rxif.rx_busy}, 32'h0);
    rst = 1'b0;
    repeat (10) @(negedge clk);

    // Single frames: latency window, payload, flags, then drain.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      fork
        send_frame(vecs[i].data, vecs[i].bad_par, vecs[i].stop_lvl);
        wait_valid(LAT_HI + 50, lat);
      join
      check_lat($sformatf("v%0d_latency", i), lat);
      check($sformatf("v%0d_data", i), {24'h0, rxif.rx_data}, {24'h0, vecs[i].exp_data});
      check($sformatf("v%0d_err", i), {30'h0, rxif.rx_err}, {30'h0, vecs[i].exp_err});
      pop();
      check($sformatf("v%0d_empty", i), {31'h0, rxif.rx_valid}, 32'h0);
      repeat (20) @(negedge clk);
    end

    // Five back-to-back frames into a 4-deep FIFO with the consumer stalled.
    o0 = ovr_seen;
    @(negedge clk);
    for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b0, 1'b1);
    repeat (DIV) @(negedge clk);
    check("overrun_pulses", ovr_seen - o0, 32'd1);
    check("head_held", {rxif.rx_valid, rxif.rx_data}, {1'b1, 8'h01});
    for (int i = 1; i <= 4; i++) begin
      check($sformatf("drain%0d", i), {rxif.rx_valid, rxif.rx_data, rxif.rx_err}, {1'b1, 8'(i), 2'b00});
      pop();
    end
    check("drain_empty", {31'h0, rxif.rx_valid}, 32'h0);
    repeat (20) @(negedge clk);

    // Break: line low for two frame times.
    @(negedge clk);
    rxif.uart_rx = 1'b0;
    fork
      repeat (2 * FRAME_BITS * DIV) @(negedge clk);
      wait_valid(LAT_HI + 50, lat);
    join
    check("break_busy", {31'h0, rxif.rx_busy}, 32'h1);
    check("break_entry", {rxif.rx_valid, rxif.rx_data, rxif.rx_err}, {1'b1, 8'h00, 2'b01});
    rxif.uart_rx = 1'b1;
    repeat (5) @(negedge clk);
    check("break_idle", {31'h0, rxif.rx_busy}, 32'h0);
    pop();
    check("break_single", {31'h0, rxif.rx_valid}, 32'h0);
    repeat (20) @(negedge clk);

    // Short low glitch must not produce a frame.
    rxif.uart_rx = 1'b0;
    repeat (DIV / 4) @(negedge clk);
    check("glitch_busy", {31'h0, rxif.rx_busy}, 32'h1);
    rxif.uart_rx = 1'b1;
    repeat (DIV) @(negedge clk);
    check("glitch_done", {rxif.rx_busy, rxif.rx_valid}, 32'h0);

    // Reset in the middle of data bit 3, then a clean frame.
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    rxif.uart_rx = 1'b0;
    repeat (DIV / 2) @(negedge clk);
    check("midframe_busy", {31'h0, rxif.rx_busy}, 32'h1);
    rst = 1'b1;
    #1;
    check("midframe_reset", {rxif.rx_valid, rxif.rx_data, rxif.rx_err, rxif.rx_overrun, rxif.rx_busy}, 32'h0);
    rxif.uart_rx = 1'b1;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    fork
      send_frame(8'h3C, 1'b0, 1'b1);
      wait_valid(LAT_HI + 50, lat);
    join
    check_lat("post_reset_latency", lat);
    check("post_reset_frame", {rxif.rx_valid, rxif.rx_data, rxif.rx_err}, {1'b1, 8'h3C, 2'b00});
    pop();
    check("post_reset_empty", {31'h0, rxif.rx_valid}, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/uart_rx_param.md
UART_RX_PARAM -- requirements
Module: uart_rx_param

Interface
REQ-001 Parameter CLK_DIV, default 434: clk cycles per bit; legal range 16..65535.
REQ-002 Parameter DATA_BITS, default 8: data bits per frame; legal range 5..8.
REQ-003 Parameter STOP_BITS, default 1: stop bits checked per frame; legal values 1 or 2.
REQ-004 Parameter PARITY_ODD, default 0: 0 selects even parity, 1 selects odd; used only when UART_RX_PARITY_EN is defined.
REQ-005 Parameter FIFO_DEPTH, default 4: receive FIFO entries; power of 2, range 2..16.
REQ-006 clk  input  1  sole clock; all logic on the rising edge.
REQ-007 rst  input  1  reset; asynchronous, active-high.
REQ-008 uart_rx  input  1  serial line; asynchronous to clk; idles high.
REQ-009 rx_data  output  8  FIFO head byte; right-aligned; bits above DATA_BITS-1 are 0.
REQ-010 rx_err  output  2  FIFO head flags: [0] framing error, [1] parity error.
REQ-011 rx_valid  output  1  FIFO not empty; rx_data and rx_err are valid.
REQ-012 rx_ready  input  1  consumer accepts the head entry when rx_valid and rx_ready are both high.
REQ-013 rx_overrun  output  1  one-cycle pulse: a completed frame was dropped because the FIFO was full.
REQ-014 rx_busy  output  1  high whenever the FSM is not in IDLE.

Function
REQ-015 uart_rx shall pass through a 2-flop synchronizer; all decoding uses the synchronized signal (rxs).
REQ-016 States: IDLE, START, DATA, PAR, STOP, BRKWAIT.
REQ-017 IDLE->START when rxs is 0 and was 1 on the previous cycle; the bit counter clears on entry.
REQ-018 START: sample rxs at count CLK_DIV/2-1 (mid-bit); 1 -> IDLE (glitch, no FIFO write); 0 -> DATA.
REQ-019 DATA: sample each bit at mid-bit (CLK_DIV cycles after the previous sample); shift LSB first; after DATA_BITS samples -> PAR if parity is compiled in, else STOP.
REQ-020 PAR: sample one bit; set the parity error if the XOR of the data bits and the parity bit is not PARITY_ODD.
REQ-021 STOP: sample STOP_BITS bits at mid-bit; any 0 sets the framing error.
REQ-022 At the last stop sample, the frame {err, data} shall be written to the FIFO on the next cycle; rx_valid rises one cycle after that write when the FIFO was empty.
REQ-023 After the last stop sample: -> IDLE if rxs is 1; -> BRKWAIT if rxs is 0; BRKWAIT -> IDLE when rxs is 1. This allows back-to-back frames with no idle gap.
REQ-024 Bit-timing counter: 16-bit; reloads to 0 at each sample point; held at 0 in IDLE.
REQ-025 FIFO full at the write point: the frame is discarded, rx_overrun pulses for 1 cycle, and FIFO contents are unchanged.
REQ-026 Simultaneous write and read when the FIFO is full: the read is performed first and the write succeeds; no overrun.
REQ-027 Write and read pointers wrap modulo FIFO_DEPTH; the count is log2(FIFO_DEPTH)+1 bits wide.
REQ-028 rx_data and rx_err shall hold stable while rx_valid is high and rx_ready is low.

Reset
REQ-029 rst asserted: FSM -> IDLE, FIFO empty, counters 0, and synchronizer flops set to 1.
REQ-030 Output values in reset: rx_valid=0, rx_data=0, rx_err=0, rx_overrun=0, rx_busy=0.
REQ-031 Reset asserted mid-frame: the partial frame is discarded; after reset releases, the next falling edge starts a new frame.

Configuration
REQ-032 Macro UART_RX_PARITY_EN.
- Defined: the PAR state exists; one parity bit is expected per frame; rx_err[1] is reported.
- Undefined: no PAR state; the frame length is 1+DATA_BITS+STOP_BITS bits; rx_err[1] is tied to 0.

Verification
REQ-033 Defaults (8N1, CLK_DIV=434, no parity): send 0x55 -> rx_valid rises with rx_data=0x55 and rx_err=00 between 434*9.5 and 434*9.5+5 cycles after the start edge.
REQ-034 UART_RX_PARITY_EN defined, PARITY_ODD=0: send 0xA3 with parity bit 1 -> rx_err=10, rx_data=0xA3.
REQ-035 Hold rx_ready=0 and send 5 frames 0x01..0x05 back-to-back -> FIFO holds 0x01..0x04; rx_overrun pulses once on the 5th frame; draining yields 0x01..0x04.
REQ-036 Line low for 2 full frame times -> one entry with rx_data=0x00, rx_err[0]=1; FSM stays in BRKWAIT until the line goes high; no second entry is written.
REQ-037 Low glitch of CLK_DIV/4 cycles while idle -> no FIFO write, rx_busy returns to 0.
REQ-038 Assert rst during the 4th data bit -> all outputs go to 0 immediately; a following frame 0x3C is received correctly.
